// File: rtl/difftest_commit_queue.sv
// -----------------------------------------------------------------------------
// difftest_commit_queue
//
// Commit-side buffer between the retire stage and the difftest bridge.
// Up to two retired instructions per cycle are compacted into program order,
// stored in a DEPTH-entry FIFO, and emitted up to two per cycle on registered
// diff lanes that connect straight to the bridge's diff_0/diff_1 ports.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, >= 4)
//   WDOG_CYCLES cycles without an emitted commit before the watchdog fires
//
// Ports:
//   clock, reset                 core clock, asynchronous active-low reset
//   in_{0,1}_valid/pc/inst/skip  retire lanes (lane 0 older)
//   in_ready                     two free slots available (from count only)
//   out_hold                     downstream hold, suppresses emission
//   diff_{0,1}_pc/inst/commit/skip  registered output lanes (0 = oldest)
//   commit_count                 entries emitted since reset. It advances on
//                                the edge that loads the commit pulses, so it
//                                already includes the pulses currently shown.
//   wdog_timeout                 sticky retire-stall flag
//
// Optional feature macro: DIFFTEST_WATCHDOG_EN (builds the watchdog counter;
// when undefined wdog_timeout is tied to 0).
// -----------------------------------------------------------------------------
module difftest_commit_queue #(
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_0_valid,
  input  logic [31:0] in_0_pc,
  input  logic [31:0] in_0_inst,
  input  logic        in_0_skip,
  input  logic        in_1_valid,
  input  logic [31:0] in_1_pc,
  input  logic [31:0] in_1_inst,
  input  logic        in_1_skip,
  output logic        in_ready,
  input  logic        out_hold,
  output logic [31:0] diff_0_pc,
  output logic [31:0] diff_0_inst,
  output logic        diff_0_commit,
  output logic        diff_0_skip,
  output logic [31:0] diff_1_pc,
  output logic [31:0] diff_1_inst,
  output logic        diff_1_commit,
  output logic        diff_1_skip,
  output logic [63:0] commit_count,
  output logic        wdog_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]    pc_mem_r   [DEPTH];
  logic [31:0]    inst_mem_r [DEPTH];
  logic [DEPTH-1:0] skip_mem_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  logic           push_0_s;
  logic           push_1_s;
  logic [AW-1:0]  slot_1_ptr_s;
  logic [AW-1:0]  rd_ptr_1_s;
  logic [1:0]     n_push_s;
  logic [1:0]     n_pop_s;

  // Push/pop decode; in_ready depends on the registered count only.
  always_comb begin
    in_ready     = ((DEPTH_C - count_r) >= CW'(2));
    push_0_s     = in_ready & in_0_valid;
    push_1_s     = in_ready & in_1_valid;
    // Lane 1 lands right after lane 0, or in lane 0's slot when lane 0 is idle.
    slot_1_ptr_s = wr_ptr_r + AW'(push_0_s);
    rd_ptr_1_s   = rd_ptr_r + AW'(1);
    n_push_s     = {1'b0, push_0_s} + {1'b0, push_1_s};
    if (out_hold) begin
      n_pop_s = 2'd0;
    end else if (count_r >= CW'(2)) begin
      n_pop_s = 2'd2;
    end else begin
      n_pop_s = count_r[1:0];
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      skip_mem_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= 32'd0;
        inst_mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_0_s) begin
        pc_mem_r[wr_ptr_r]   <= in_0_pc;
        inst_mem_r[wr_ptr_r] <= in_0_inst;
        skip_mem_r[wr_ptr_r] <= in_0_skip;
      end
      if (push_1_s) begin
        pc_mem_r[slot_1_ptr_s]   <= in_1_pc;
        inst_mem_r[slot_1_ptr_s] <= in_1_inst;
        skip_mem_r[slot_1_ptr_s] <= in_1_skip;
      end
      wr_ptr_r <= wr_ptr_r + AW'(n_push_s);
      rd_ptr_r <= rd_ptr_r + AW'(n_pop_s);
      count_r  <= count_r + CW'(n_push_s) - CW'(n_pop_s);
    end
  end

  // Output lane registers and emitted-commit counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      diff_0_pc     <= 32'd0;
      diff_0_inst   <= 32'd0;
      diff_0_commit <= 1'b0;
      diff_0_skip   <= 1'b0;
      diff_1_pc     <= 32'd0;
      diff_1_inst   <= 32'd0;
      diff_1_commit <= 1'b0;
      diff_1_skip   <= 1'b0;
      commit_count  <= 64'd0;
    end else begin
      if (out_hold) begin
        // pc/inst keep their last values; only the qualifiers drop.
        diff_0_commit <= 1'b0;
        diff_0_skip   <= 1'b0;
        diff_1_commit <= 1'b0;
        diff_1_skip   <= 1'b0;
      end else begin
        diff_0_commit <= (n_pop_s != 2'd0);
        diff_0_pc     <= (n_pop_s != 2'd0) ? pc_mem_r[rd_ptr_r]   : 32'd0;
        diff_0_inst   <= (n_pop_s != 2'd0) ? inst_mem_r[rd_ptr_r] : 32'd0;
        diff_0_skip   <= (n_pop_s != 2'd0) & skip_mem_r[rd_ptr_r];
        diff_1_commit <= (n_pop_s == 2'd2);
        diff_1_pc     <= (n_pop_s == 2'd2) ? pc_mem_r[rd_ptr_1_s]   : 32'd0;
        diff_1_inst   <= (n_pop_s == 2'd2) ? inst_mem_r[rd_ptr_1_s] : 32'd0;
        diff_1_skip   <= (n_pop_s == 2'd2) & skip_mem_r[rd_ptr_1_s];
      end
      commit_count <= commit_count + 64'(n_pop_s);
    end
  end

`ifdef DIFFTEST_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_C = WW'(WDOG_CYCLES);

  logic [WW-1:0] wdog_cnt_r;
  logic [WW-1:0] wdog_cnt_next_s;

  // Stall counter: cleared by any commit load, saturates at the limit.
  always_comb begin
    if (n_pop_s != 2'd0) begin
      wdog_cnt_next_s = '0;
    end else if (wdog_cnt_r == WDOG_C) begin
      wdog_cnt_next_s = wdog_cnt_r;
    end else begin
      wdog_cnt_next_s = wdog_cnt_r + WW'(1);
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt_r   <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      wdog_cnt_r   <= wdog_cnt_next_s;
      wdog_timeout <= wdog_timeout | (wdog_cnt_next_s == WDOG_C);
    end
  end
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule
